// File: rtl/morse_seq_module.sv
// morse_seq_module: programmable Morse sequencer.
// Plays up to MAX_SYM dot/dash symbols, latched at Start_Sig, on Pin_Out with
// standard Morse timing (dot 1 unit, dash 3, inter-symbol gap 1, letter gap 3).
// Optional feature macro: MORSE_SEQ_REPEAT_EN adds Rep_Num[3:0]; the pattern
// is then played Rep_Num+1 times with a 7-unit word gap between passes.
module morse_seq_module #(
    parameter int UNIT_CYCLES = 4,
    parameter int MAX_SYM     = 16,
    parameter int SYM_W       = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start_Sig,
    input  logic [SYM_W-1:0]   Sym_Count,
    input  logic [MAX_SYM-1:0] Sym_Pattern,
`ifdef MORSE_SEQ_REPEAT_EN
    input  logic [3:0]         Rep_Num,
`endif
    output logic               Busy,
    output logic               Done_Sig,
    output logic               Pin_Out
);

    localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
    localparam logic [SYM_W-1:0] SYM_MAX  = SYM_W'(MAX_SYM);

    typedef enum logic [2:0] {
        S_IDLE, S_MARK, S_GAP, S_WORD, S_TAIL, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;     // clock cycles within the current unit
    logic [2:0]         unit_q, unit_d;   // units elapsed in the current state
    logic [SYM_W-1:0]   idx_q, idx_d;     // symbol being played
    logic [SYM_W-1:0]   cnt_q, cnt_d;     // clamped symbol count
    logic [MAX_SYM-1:0] pat_q, pat_d;
    logic               pin_q, pin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               more_pass;
    logic [SYM_W-1:0]   cnt_clamped;
    logic [MAX_SYM-1:0] pat_sh;
    logic               cur_dash;
    logic [2:0]         dur_m1;
    logic               unit_end;
    logic               state_end;
    logic               more_sym;

`ifdef MORSE_SEQ_REPEAT_EN
    logic [3:0] rep_q, rep_d;     // extra passes requested
    logic [3:0] pass_q, pass_d;   // passes already completed
    assign more_pass = (pass_q != rep_q);
`else
    assign more_pass = 1'b0;
`endif

    assign cnt_clamped = (Sym_Count > SYM_MAX) ? SYM_MAX : Sym_Count;
    assign pat_sh      = pat_q >> idx_q;
    assign cur_dash    = pat_sh[0];
    assign unit_end    = (cyc_q == CYC_LAST);
    assign state_end   = unit_end && (unit_q == dur_m1);
    assign more_sym    = ({1'b0, idx_q} + {{SYM_W{1'b0}}, 1'b1}) < {1'b0, cnt_q};

    // Length of the current timed state, in units minus one
    always_comb begin
        dur_m1 = 3'd0;
        case (state_q)
            S_MARK:  dur_m1 = cur_dash ? 3'd2 : 3'd0;
            S_GAP:   dur_m1 = 3'd0;
            S_WORD:  dur_m1 = 3'd6;
            S_TAIL:  dur_m1 = 3'd2;
            default: dur_m1 = 3'd0;
        endcase
    end

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        unit_d  = unit_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        pin_d   = pin_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef MORSE_SEQ_REPEAT_EN
        rep_d   = rep_q;
        pass_d  = pass_q;
`endif
        // Unit timebase runs in every timed state; a state exit clears it so
        // the next state always starts from a fresh unit.
        if (state_q == S_MARK || state_q == S_GAP ||
            state_q == S_WORD || state_q == S_TAIL) begin
            if (unit_end) begin
                cyc_d  = '0;
                unit_d = unit_q + 3'd1;
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
            end
            if (state_end) begin
                cyc_d  = '0;
                unit_d = '0;
            end
        end

        case (state_q)
            S_IDLE: begin
                cyc_d  = '0;
                unit_d = '0;
                if (Start_Sig) begin
                    cnt_d  = cnt_clamped;
                    pat_d  = Sym_Pattern;
                    idx_d  = '0;
                    busy_d = 1'b1;
`ifdef MORSE_SEQ_REPEAT_EN
                    rep_d  = Rep_Num;
                    pass_d = '0;
`endif
                    if (cnt_clamped == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_MARK;
                        pin_d   = 1'b1;
                    end
                end
            end
            S_MARK: begin
                if (state_end) begin
                    pin_d = 1'b0;
                    if (more_sym)       state_d = S_GAP;
                    else if (more_pass) state_d = S_WORD;
                    else                state_d = S_TAIL;
                end
            end
            S_GAP: begin
                if (state_end) begin
                    idx_d   = idx_q + SYM_W'(1);
                    pin_d   = 1'b1;
                    state_d = S_MARK;
                end
            end
            S_WORD: begin
                if (state_end) begin
                    idx_d   = '0;
`ifdef MORSE_SEQ_REPEAT_EN
                    pass_d  = pass_q + 4'd1;
`endif
                    pin_d   = 1'b1;
                    state_d = S_MARK;
                end
            end
            S_TAIL: begin
                if (state_end) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                pin_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything to idle at once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            pin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MORSE_SEQ_REPEAT_EN
            rep_q   <= '0;
            pass_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MORSE_SEQ_REPEAT_EN
            rep_q   <= rep_d;
            pass_q  <= pass_d;
`endif
        end
    end

    assign Pin_Out  = pin_q;
    assign Busy     = busy_q;
    assign Done_Sig = done_q;

endmodule

// File: tb/tb_morse_seq_module.sv
// Directed bench for morse_seq_module: one instance at UNIT_CYCLES=2 and one
// at UNIT_CYCLES=4, sharing pattern/count inputs but with separate starts.
module tb_morse_seq_module;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start2 = 1'b0;
    logic        start4 = 1'b0;
    logic [4:0]  cnt = '0;
    logic [15:0] pat = '0;
`ifdef MORSE_SEQ_REPEAT_EN
    logic [3:0]  rep = '0;
`endif
    logic busy2, done2, pin2, busy4, done4, pin4;

    int errors = 0;
    int checks = 0;

    bit cap_pin  [0:127];
    bit cap_busy [0:127];
    bit cap_done [0:127];
    int hi_q[$];
    int lo_q[$];
    int done_cnt, done_first, busy_first, busy_last, hi_total;

    always #5 clk = ~clk;

    morse_seq_module #(.UNIT_CYCLES(2), .MAX_SYM(16), .SYM_W(5)) u2 (
        .CLK(clk), .RST(rst), .Start_Sig(start2), .Sym_Count(cnt),
        .Sym_Pattern(pat),
`ifdef MORSE_SEQ_REPEAT_EN
        .Rep_Num(rep),
`endif
        .Busy(busy2), .Done_Sig(done2), .Pin_Out(pin2));

    morse_seq_module #(.UNIT_CYCLES(4), .MAX_SYM(16), .SYM_W(5)) u4 (
        .CLK(clk), .RST(rst), .Start_Sig(start4), .Sym_Count(cnt),
        .Sym_Pattern(pat),
`ifdef MORSE_SEQ_REPEAT_EN
        .Rep_Num(4'd0),
`endif
        .Busy(busy4), .Done_Sig(done4), .Pin_Out(pin4));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start pulse sampled at the edge ending cycle 0; record cycles 1..n.
    // mode 0: plain, 1: random start/pattern/count noise for cycles 1..39,
    // 2: Start held high throughout.
    task automatic capture(input int sel, input int n, input int mode);
        @(negedge clk);
        if (sel == 4) start4 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (mode != 2) begin start2 = 1'b0; start4 = 1'b0; end
            cap_pin[k]  = (sel == 4) ? pin4  : pin2;
            cap_busy[k] = (sel == 4) ? busy4 : busy2;
            cap_done[k] = (sel == 4) ? done4 : done2;
            if (mode == 1 && k < 40) begin
                start2 = 1'($urandom_range(0, 1));
                pat    = 16'($urandom);
                cnt    = 5'($urandom);
            end
        end
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    // Reduce a capture to mark run lengths, inter-mark lows and event cycles
    task automatic analyze(input int n);
        bit cur;
        bit had_hi;
        int run;
        hi_q.delete(); lo_q.delete();
        cur = 1'b0; had_hi = 1'b0; run = 0;
        done_cnt = 0; done_first = -1; busy_first = -1; busy_last = -1;
        hi_total = 0;
        for (int k = 1; k <= n; k++) begin
            if (cap_pin[k] == cur) run++;
            else begin
                if (cur) begin hi_q.push_back(run); had_hi = 1'b1; end
                else if (had_hi) lo_q.push_back(run);
                cur = cap_pin[k];
                run = 1;
            end
            if (cap_pin[k]) hi_total++;
            if (cap_done[k]) begin
                done_cnt++;
                if (done_first < 0) done_first = k;
            end
            if (cap_busy[k]) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
        end
        if (cur) hi_q.push_back(run);
    endtask

    task automatic chk_runs(input string tag, input int obs[$], input int exp[$]);
        chk({tag, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_hi[$];
        int exp_lo[$];
        int dcount;

        // ---- reset state
        idle(3);
        chk("rst_pin2", int'(pin2), 0);
        chk("rst_busy2", int'(busy2), 0);
        chk("rst_done2", int'(done2), 0);
        chk("rst_busy4", int'(busy4), 0);
        rst = 1'b0;
        idle(2);

        // ---- single dot at UNIT_CYCLES=4
        cnt = 5'd1; pat = 16'h0000;
        capture(4, 20, 0);
        analyze(20);
        exp_hi = '{4};
        chk_runs("dot4_hi", hi_q, exp_hi);
        chk("dot4_pin_first", int'(cap_pin[1]), 1);
        chk("dot4_pin_c5", int'(cap_pin[5]), 0);
        chk("dot4_done_at", done_first, 17);
        chk("dot4_done_cnt", done_cnt, 1);
        chk("dot4_busy_first", busy_first, 1);
        chk("dot4_busy_last", busy_last, 17);
        chk("dot4_busy_c18", int'(cap_busy[18]), 0);
        idle(3);

        // ---- SOS
        cnt = 5'd9; pat = 16'h0038;
        capture(2, 56, 0);
        analyze(56);
        exp_hi = '{2, 2, 2, 6, 6, 6, 2, 2, 2};
        exp_lo = '{2, 2, 2, 2, 2, 2, 2, 2};
        chk_runs("sos_hi", hi_q, exp_hi);
        chk_runs("sos_lo", lo_q, exp_lo);
        chk("sos_hi_total", hi_total, 30);
        chk("sos_done_at", done_first, 53);
        chk("sos_done_cnt", done_cnt, 1);
        chk("sos_busy_last", busy_last, 53);
        chk("sos_pin_c53", int'(cap_pin[53]), 0);
        idle(3);

        // ---- zero-length pattern
        cnt = 5'd0; pat = 16'hFFFF;
        capture(2, 5, 0);
        analyze(5);
        chk("zero_done_at", done_first, 1);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_busy_first", busy_first, 1);
        chk("zero_busy_last", busy_last, 1);
        chk("zero_hi_total", hi_total, 0);
        idle(3);

        // ---- SOS with start/pattern/count noise while busy
        cnt = 5'd9; pat = 16'h0038;
        capture(2, 56, 1);
        analyze(56);
        chk_runs("noise_hi", hi_q, exp_hi);
        chk_runs("noise_lo", lo_q, exp_lo);
        chk("noise_done_at", done_first, 53);
        chk("noise_done_cnt", done_cnt, 1);
        chk("noise_busy_last", busy_last, 53);
        idle(3);

        // ---- count above MAX_SYM clamps to 16 dots
        cnt = 5'd20; pat = 16'h0000;
        capture(2, 72, 0);
        analyze(72);
        chk("clamp_marks", hi_q.size(), 16);
        chk("clamp_hi_total", hi_total, 32);
        chk("clamp_done_at", done_first, 69);
        chk("clamp_busy_last", busy_last, 69);
        idle(3);

        // ---- Start held high: restart after one idle cycle
        cnt = 5'd1; pat = 16'h0000;
        capture(2, 14, 2);
        analyze(14);
        chk("hold_done_at", done_first, 9);
        chk("hold_busy_c10", int'(cap_busy[10]), 0);
        chk("hold_pin_c11", int'(cap_pin[11]), 1);
        chk("hold_busy_c11", int'(cap_busy[11]), 1);
        idle(20);
        chk("hold_settled_busy", int'(busy2), 0);

        // ---- reset in the middle of a dash
        cnt = 5'd1; pat = 16'h0001;
        @(negedge clk); start2 = 1'b1;
        @(posedge clk);
        @(negedge clk); start2 = 1'b0;
        idle(2);
        chk("mid_pin_before_rst", int'(pin2), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pin", int'(pin2), 0);
        chk("mid_rst_busy", int'(busy2), 0);
        chk("mid_rst_done", int'(done2), 0);
        @(negedge clk); rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done2) dcount++;
        end
        chk("mid_rst_no_done", dcount, 0);
        cnt = 5'd1; pat = 16'h0000;
        capture(2, 12, 0);
        analyze(12);
        chk("post_rst_pin_c1", int'(cap_pin[1]), 1);
        chk("post_rst_done_at", done_first, 9);
        idle(3);

`ifdef MORSE_SEQ_REPEAT_EN
        // ---- repeated single dash, two passes
        cnt = 5'd1; pat = 16'h0001; rep = 4'd1;
        capture(2, 40, 0);
        analyze(40);
        exp_hi = '{6, 6};
        exp_lo = '{14};
        chk_runs("rep_hi", hi_q, exp_hi);
        chk_runs("rep_lo", lo_q, exp_lo);
        chk("rep_done_at", done_first, 33);
        chk("rep_done_cnt", done_cnt, 1);
        chk("rep_busy_last", busy_last, 33);
        rep = 4'd0;
        idle(3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
